network_interface: RTL and testbench

NETWORK_INTERFACE -- requirements
Module: network_interface

---
 rtl/network_interface.sv | 137 +++++++++++++
 tb/tb_network_interface.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/network_interface.sv
// Network interface between a local PE and a router port: credit-controlled
// injection FIFO toward the router, ejection FIFO with credit return toward it.
module network_interface #(
  parameter int FLIT_W    = 20,
  parameter int CREDITS   = 4,
  parameter int INJ_DEPTH = 8,
  parameter int EJ_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         RST,
  input  logic [FLIT_W-1:0]            inj_data,
  input  logic                         inj_valid,
  output logic                         inj_ready,
  output logic [FLIT_W-1:0]            o,
  output logic                         vo,
  input  logic                         ci,
  input  logic [FLIT_W-1:0]            in,
  input  logic                         vi,
  output logic                         co,
  output logic [FLIT_W-1:0]            ej_data,
  output logic                         ej_valid,
  input  logic                         ej_ready,
  output logic [$clog2(CREDITS+1)-1:0] credit_cnt,
  output logic [15:0]                  sent_cnt,
  output logic [15:0]                  recv_cnt,
  output logic [1:0]                   err
);

  localparam int CW  = $clog2(CREDITS + 1);
  localparam int IAW = $clog2(INJ_DEPTH);
  localparam int EAW = $clog2(EJ_DEPTH);

  // ---------------------------------------------------------------- injection
  logic [FLIT_W-1:0] inj_mem [INJ_DEPTH];
  logic [IAW-1:0]    inj_wptr, inj_rptr;
  logic [IAW:0]      inj_count;
  logic              running;
  logic              inj_push, send, inj_full, inj_empty;

  assign inj_full  = (inj_count == (IAW+1)'(INJ_DEPTH));
  assign inj_empty = (inj_count == '0);
  // Ready is held low during reset and rises on the first edge after release.
  assign inj_ready = running && !inj_full;
  assign inj_push  = inj_valid && inj_ready;
  assign send      = !inj_empty && (credit_cnt != '0);

  // NOTE: FIFO storage has no reset; occupancy counters alone define validity,
  // which keeps the array mappable onto plain RAM/flop arrays without reset.
  always_ff @(posedge clk) begin
    if (inj_push) inj_mem[inj_wptr] <= inj_data;
  end

  // NOTE: all state uses non-blocking assignment so every flop samples the
  // pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      running   <= 1'b0;
      inj_wptr  <= '0;
      inj_rptr  <= '0;
      inj_count <= '0;
      o         <= '0;
      vo        <= 1'b0;
    end else begin
      running <= 1'b1;
      vo      <= send;
      if (inj_push) inj_wptr <= inj_wptr + IAW'(1);
      if (send) begin
        inj_rptr <= inj_rptr + IAW'(1);
        o        <= inj_mem[inj_rptr];
      end
      unique case ({inj_push, send})
        2'b10:   inj_count <= inj_count + (IAW+1)'(1);
        2'b01:   inj_count <= inj_count - (IAW+1)'(1);
        default: inj_count <= inj_count;
      endcase
    end
  end

  // ----------------------------------------------------------------- ejection
  logic [FLIT_W-1:0] ej_mem [EJ_DEPTH];
  logic [EAW-1:0]    ej_wptr, ej_rptr;
  logic [EAW:0]      ej_count;
  logic              ej_full, ej_pop, ej_write, ej_drop;

  assign ej_full  = (ej_count == (EAW+1)'(EJ_DEPTH));
  assign ej_valid = (ej_count != '0);
  assign ej_data  = ej_mem[ej_rptr];
  assign ej_pop   = ej_valid && ej_ready;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign ej_write = vi && (!ej_full || ej_pop);
  assign ej_drop  = vi && ej_full && !ej_pop;

  always_ff @(posedge clk) begin
    if (ej_write) ej_mem[ej_wptr] <= in;
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      ej_wptr  <= '0;
      ej_rptr  <= '0;
      ej_count <= '0;
      co       <= 1'b0;
    end else begin
      co <= ej_pop;
      if (ej_write) ej_wptr <= ej_wptr + EAW'(1);
      if (ej_pop)   ej_rptr <= ej_rptr + EAW'(1);
      unique case ({ej_write, ej_pop})
        2'b10:   ej_count <= ej_count + (EAW+1)'(1);
        2'b01:   ej_count <= ej_count - (EAW+1)'(1);
        default: ej_count <= ej_count;
      endcase
    end
  end

  // ------------------------------------------------- credits, counters, errors
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      credit_cnt <= CW'(CREDITS);
      sent_cnt   <= '0;
      recv_cnt   <= '0;
      err        <= '0;
    end else begin
      unique case ({send, ci})
        2'b10: credit_cnt <= credit_cnt - CW'(1);
        2'b01: begin
          if (credit_cnt == CW'(CREDITS)) err[0] <= 1'b1;
          else                            credit_cnt <= credit_cnt + CW'(1);
        end
        default: credit_cnt <= credit_cnt;
      endcase
      if (send)     sent_cnt <= sent_cnt + 16'd1;
      if (ej_write) recv_cnt <= recv_cnt + 16'd1;
      if (ej_drop)  err[1]   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_network_interface.sv
// Directed bench for network_interface: a per-cycle vector table for the
// injection/credit path plus hand sequences for ejection, overflow and reset.
module tb_network_interface;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] inj_data, o, in, ej_data;
  logic        inj_valid, inj_ready, vo, ci, vi, co, ej_valid, ej_ready;
  logic [2:0]  credit_cnt;
  logic [15:0] sent_cnt, recv_cnt;
  logic [1:0]  err;

  int n_cmp  = 0;
  int n_fail = 0;

  network_interface dut (
    .clk       (clk),
    .RST       (rst_n),
    .inj_data  (inj_data),
    .inj_valid (inj_valid),
    .inj_ready (inj_ready),
    .o         (o),
    .vo        (vo),
    .ci        (ci),
    .in        (in),
    .vi        (vi),
    .co        (co),
    .ej_data   (ej_data),
    .ej_valid  (ej_valid),
    .ej_ready  (ej_ready),
    .credit_cnt(credit_cnt),
    .sent_cnt  (sent_cnt),
    .recv_cnt  (recv_cnt),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [19:0] id;
    logic        ci;
    logic        vo;
    logic [19:0] o;
    logic [2:0]  cr;
    logic [15:0] sent;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Six pushes with four credits, then two credit returns.
    tbl[0]  = '{1'b1, 20'h00001, 1'b0, 1'b0, 20'h00000, 3'd4, 16'd0};
    tbl[1]  = '{1'b1, 20'h00002, 1'b0, 1'b1, 20'h00001, 3'd3, 16'd1};
    tbl[2]  = '{1'b1, 20'h00003, 1'b0, 1'b1, 20'h00002, 3'd2, 16'd2};
    tbl[3]  = '{1'b1, 20'h00004, 1'b0, 1'b1, 20'h00003, 3'd1, 16'd3};
    tbl[4]  = '{1'b1, 20'h00005, 1'b0, 1'b1, 20'h00004, 3'd0, 16'd4};
    tbl[5]  = '{1'b1, 20'h00006, 1'b0, 1'b0, 20'h00004, 3'd0, 16'd4};
    tbl[6]  = '{1'b0, 20'h00000, 1'b0, 1'b0, 20'h00004, 3'd0, 16'd4};
    tbl[7]  = '{1'b0, 20'h00000, 1'b1, 1'b0, 20'h00004, 3'd1, 16'd4};
    tbl[8]  = '{1'b0, 20'h00000, 1'b1, 1'b1, 20'h00005, 3'd1, 16'd5};
    tbl[9]  = '{1'b0, 20'h00000, 1'b0, 1'b1, 20'h00006, 3'd0, 16'd6};
    tbl[10] = '{1'b0, 20'h00000, 1'b0, 1'b0, 20'h00006, 3'd0, 16'd6};

    inj_data = '0; inj_valid = 1'b0; ci = 1'b0;
    in = '0; vi = 1'b0; ej_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst inj_ready", inj_ready, 0);
    check("rst vo", vo, 0);
    check("rst co", co, 0);
    check("rst ej_valid", ej_valid, 0);
    check("rst credit", credit_cnt, 4);
    check("rst sent", sent_cnt, 0);
    check("rst recv", recv_cnt, 0);
    check("rst err", err, 0);
    check("rst o", o, 0);

    rst_n = 1'b1;
    step();
    check("post-rst inj_ready", inj_ready, 1);

    for (int i = 0; i < 11; i++) begin
      inj_valid = tbl[i].iv;
      inj_data  = tbl[i].id;
      ci        = tbl[i].ci;
      step();
      check($sformatf("vec%0d vo", i), vo, tbl[i].vo);
      check($sformatf("vec%0d o", i), o, tbl[i].o);
      check($sformatf("vec%0d credit", i), credit_cnt, tbl[i].cr);
      check($sformatf("vec%0d sent", i), sent_cnt, tbl[i].sent);
    end
    inj_valid = 1'b0; ci = 1'b0;

    // Credit returned on the same edge as a send; then overflow at full credit.
    ci = 1'b1;
    step(); step();
    ci = 1'b0;
    check("credit refill", credit_cnt, 2);
    inj_valid = 1'b1; inj_data = 20'h00007;
    step();
    inj_valid = 1'b0; ci = 1'b1;
    step();
    check("ci+send vo", vo, 1);
    check("ci+send o", o, 20'h00007);
    check("ci+send credit", credit_cnt, 2);
    step(); step();
    check("credit full", credit_cnt, 4);
    check("no err yet", err, 0);
    step();
    ci = 1'b0;
    check("overflow credit", credit_cnt, 4);
    check("overflow err", err, 2'b01);
    check("sent after ci", sent_cnt, 7);

    // Ejection overflow with PE stalled, then drain.
    for (int i = 0; i < 5; i++) begin
      vi = 1'b1; in = 20'hA0000 + 20'(i);
      step();
      if (i == 0) check("ej_valid rise", ej_valid, 1);
    end
    vi = 1'b0;
    check("ej drop err", err, 2'b11);
    check("ej recv", recv_cnt, 4);
    check("ej no co", co, 0);
    ej_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ej head%0d", i), ej_data, 20'hA0000 + 20'(i));
      step();
      check($sformatf("ej co%0d", i), co, 1);
    end
    ej_ready = 1'b0;
    check("ej empty", ej_valid, 0);
    step();
    check("ej co end", co, 0);

    // Full ejection FIFO accepts a write when a pop happens on the same edge.
    for (int i = 0; i < 4; i++) begin
      vi = 1'b1; in = 20'hB0000 + 20'(i);
      step();
    end
    in = 20'hB0004; ej_ready = 1'b1;
    step();
    vi = 1'b0; ej_ready = 1'b0;
    check("full+pop recv", recv_cnt, 9);
    ej_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check($sformatf("full+pop head%0d", i), ej_data, 20'hB0000 + 20'(i));
      step();
    end
    ej_ready = 1'b0;
    check("full+pop drained", ej_valid, 0);
    check("err sticky", err, 2'b11);

    // Fill the injection FIFO with no credit return.
    for (int i = 0; i < 12; i++) begin
      inj_valid = 1'b1; inj_data = 20'h00100 + 20'(i);
      step();
      if (i == 10) check("inj ready before full", inj_ready, 1);
    end
    check("inj full ready", inj_ready, 0);
    check("inj full credit", credit_cnt, 0);
    check("inj full vo", vo, 0);
    check("inj full o", o, 20'h00103);
    check("inj full sent", sent_cnt, 11);
    inj_data = 20'h0BEEF; ci = 1'b1;
    step();
    ci = 1'b0;
    check("full ci ready", inj_ready, 0);
    check("full ci credit", credit_cnt, 1);
    step();
    check("full send vo", vo, 1);
    check("full send o", o, 20'h00104);
    check("full send ready", inj_ready, 1);
    step();
    check("refull ready", inj_ready, 0);
    inj_valid = 1'b0;

    // Reset mid-stream.
    rst_n = 1'b0;
    #1;
    check("midrst vo", vo, 0);
    check("midrst credit", credit_cnt, 4);
    check("midrst inj_ready", inj_ready, 0);
    check("midrst sent", sent_cnt, 0);
    check("midrst err", err, 0);
    repeat (2) @(posedge clk);
    #1;
    check("midrst hold vo", vo, 0);
    rst_n = 1'b1;
    step();
    check("release inj_ready", inj_ready, 1);
    check("release vo", vo, 0);
    step();
    check("discarded vo", vo, 0);
    check("discarded ej_valid", ej_valid, 0);
    check("discarded co", co, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
